// File: rtl/domain_reset_responder.sv
// Per-domain reset responder: stretches a one-cycle reset pulse into a local reset,
// then waits for the datapath's INIT_DONE with bounded retries before declaring a fault.
module domain_reset_responder #(
  parameter int HOLD_CYCLES    = 16,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int MAX_RETRY      = 3,
  localparam int RCW     = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1,
  localparam int CNT_MAX = (HOLD_CYCLES > TIMEOUT_CYCLES) ? HOLD_CYCLES : TIMEOUT_CYCLES,
  localparam int CW      = $clog2(CNT_MAX + 1)
) (
  input  logic           SYS_CLK,
  input  logic           RST_N,
  input  logic           RST_PULSE,
  input  logic           INIT_DONE,
  output logic           LOCAL_RST,
  output logic           DOMAIN_READY,
  output logic           RETRY_REQ,
  output logic           TIMEOUT_ERR,
  output logic [RCW-1:0] RETRY_CNT
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    HOLD     = 3'd1,
    WAIT_RDY = 3'd2,
    READY    = 3'd3,
    FAULT    = 3'd4
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [RCW-1:0] retry_cnt_q, retry_cnt_d;
  logic           retry_req_q, retry_req_d;
  logic           local_rst_q, local_rst_d;
  logic           domain_ready_q, domain_ready_d;
  logic           timeout_err_q, timeout_err_d;

  // Next-state, counters and next-output values; outputs are derived from the next state
  // so the registered outputs always agree with the state they describe.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    retry_cnt_d = retry_cnt_q;
    retry_req_d = 1'b0;

    if (RST_PULSE) begin
      state_d     = HOLD;
      cnt_d       = '0;
      retry_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        HOLD: begin
          if (cnt_q == CW'(HOLD_CYCLES)) begin
            state_d = WAIT_RDY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        WAIT_RDY: begin
          // INIT_DONE wins over a timeout landing on the same edge.
          if (INIT_DONE) begin
            state_d = READY;
            cnt_d   = '0;
          end else if (cnt_q == CW'(TIMEOUT_CYCLES)) begin
            cnt_d = '0;
            if (retry_cnt_q < RCW'(MAX_RETRY)) begin
              state_d     = HOLD;
              retry_cnt_d = retry_cnt_q + RCW'(1);
              retry_req_d = 1'b1;
            end else begin
              state_d = FAULT;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        READY: begin
          if (!INIT_DONE) begin
            state_d = WAIT_RDY;
            cnt_d   = '0;
          end else begin
            state_d = READY;
          end
        end
        FAULT: begin
          state_d = FAULT;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    local_rst_d    = (state_d == IDLE) || (state_d == HOLD) || (state_d == FAULT);
    domain_ready_d = (state_d == READY);
    timeout_err_d  = (state_d == FAULT);
  end

  // State, counter and registered-output flops.
  always_ff @(posedge SYS_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      retry_cnt_q    <= '0;
      retry_req_q    <= 1'b0;
      local_rst_q    <= 1'b1;
      domain_ready_q <= 1'b0;
      timeout_err_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      retry_cnt_q    <= retry_cnt_d;
      retry_req_q    <= retry_req_d;
      local_rst_q    <= local_rst_d;
      domain_ready_q <= domain_ready_d;
      timeout_err_q  <= timeout_err_d;
    end
  end

  assign LOCAL_RST    = local_rst_q;
  assign DOMAIN_READY = domain_ready_q;
  assign RETRY_REQ    = retry_req_q;
  assign TIMEOUT_ERR  = timeout_err_q;
  assign RETRY_CNT    = retry_cnt_q;

endmodule

// File: tb/tb_domain_reset_responder.sv
// Scoreboard bench: a timestamp-based reference model pushes the expected outputs for every
// clock edge; a monitor on the falling edge pops and compares against the DUT.
module tb_domain_reset_responder;

  localparam int H  = 16;
  localparam int T  = 8;
  localparam int MR = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pulse = 1'b0;
  logic       init = 1'b0;
  logic       lr, dr, rq, te;
  logic [1:0] rc;

  typedef struct packed {
    logic       lr;
    logic       dr;
    logic       rq;
    logic       te;
    logic [1:0] rc;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   rq_seen = 0;

  domain_reset_responder #(.HOLD_CYCLES(H), .TIMEOUT_CYCLES(T), .MAX_RETRY(MR)) dut (
    .SYS_CLK(clk), .RST_N(rst_n), .RST_PULSE(pulse), .INIT_DONE(init),
    .LOCAL_RST(lr), .DOMAIN_READY(dr), .RETRY_REQ(rq), .TIMEOUT_ERR(te), .RETRY_CNT(rc)
  );

  always #5 clk = ~clk;

  // Reference model: phases tracked with absolute edge timestamps.
  localparam int P_IDLE = 0, P_HOLD = 1, P_WAIT = 2, P_READY = 3, P_FAULT = 4;
  int   phase = P_IDLE;
  int   edge_no = 0;
  int   hold_last = 0;  // last edge whose output still shows the hold
  int   deadline = 0;   // edge on which an unanswered wait times out
  int   retries = 0;
  logic req_now;
  exp_t e;

  always @(posedge clk) begin
    edge_no = edge_no + 1;
    req_now = 1'b0;
    if (!rst_n) begin
      phase = P_IDLE;
      retries = 0;
    end else if (pulse) begin
      phase = P_HOLD;
      hold_last = edge_no + H;
      retries = 0;
    end else if (phase == P_HOLD && edge_no > hold_last) begin
      phase = P_WAIT;
      deadline = edge_no + T + 1;
    end else if (phase == P_WAIT && init) begin
      phase = P_READY;
    end else if (phase == P_WAIT && edge_no == deadline) begin
      if (retries < MR) begin
        retries = retries + 1;
        req_now = 1'b1;
        phase = P_HOLD;
        hold_last = edge_no + H;
      end else begin
        phase = P_FAULT;
      end
    end else if (phase == P_READY && !init) begin
      phase = P_WAIT;
      deadline = edge_no + T + 1;
    end
    e.lr = (phase == P_IDLE) || (phase == P_HOLD) || (phase == P_FAULT);
    e.dr = (phase == P_READY);
    e.te = (phase == P_FAULT);
    e.rq = req_now;
    e.rc = 2'(retries);
    exp_q.push_back(e);
  end

  // Monitor: asynchronous reset forces reset values regardless of the last edge.
  exp_t w;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      w = exp_q.pop_front();
      if (!rst_n) begin
        w = '{lr: 1'b1, dr: 1'b0, rq: 1'b0, te: 1'b0, rc: 2'd0};
      end
      total = total + 1;
      if (rq) rq_seen = rq_seen + 1;
      if ({lr, dr, rq, te, rc} !== w) begin
        bad = bad + 1;
        $display("FAIL outputs @%0t: got lr=%0b dr=%0b rq=%0b te=%0b rc=%0d want lr=%0b dr=%0b rq=%0b te=%0b rc=%0d",
                 $time, lr, dr, rq, te, rc, w.lr, w.dr, w.rq, w.te, w.rc);
      end
    end
  end

  task automatic drive(input logic p, input logic i, input logic r, input int n);
    for (int k = 0; k < n; k++) begin
      pulse = p;
      init  = i;
      rst_n = r;
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    int rst_before;
    repeat (3) @(posedge clk);
    #2;
    // Released reset alone must not start a sequence.
    drive(1'b0, 1'b1, 1'b1, 6);
    // Full retry exhaustion into FAULT, then linger.
    drive(1'b1, 1'b0, 1'b1, 1);
    drive(1'b0, 1'b0, 1'b1, 100);
    // Recover from FAULT; INIT_DONE five cycles after local reset falls.
    drive(1'b1, 1'b0, 1'b1, 1);
    drive(1'b0, 1'b0, 1'b1, H + 6);
    drive(1'b0, 1'b1, 1'b1, 6);
    // Short INIT_DONE dropout in READY.
    drive(1'b0, 1'b0, 1'b1, 3);
    drive(1'b0, 1'b1, 1'b1, 5);
    // INIT_DONE returns exactly on the timeout edge.
    drive(1'b0, 1'b0, 1'b1, T + 1);
    drive(1'b0, 1'b1, 1'b1, 5);
    // RST_PULSE coincident with INIT_DONE while waiting.
    drive(1'b0, 1'b0, 1'b1, 3);
    drive(1'b1, 1'b1, 1'b1, 1);
    drive(1'b0, 1'b1, 1'b1, H + 5);
    // RST_N mid-HOLD, then mid-WAIT_RDY.
    drive(1'b1, 1'b0, 1'b1, 1);
    drive(1'b0, 1'b0, 1'b1, 5);
    drive(1'b0, 1'b0, 1'b0, 2);
    drive(1'b0, 1'b1, 1'b1, 10);
    drive(1'b1, 1'b0, 1'b1, 1);
    drive(1'b0, 1'b0, 1'b1, H + 4);
    drive(1'b0, 1'b0, 1'b0, 1);
    drive(1'b0, 1'b0, 1'b1, 10);
    // Held multi-cycle pulse.
    drive(1'b1, 1'b0, 1'b1, 3);
    drive(1'b0, 1'b0, 1'b1, H + 3);
    drive(1'b0, 1'b1, 1'b1, 3);
    rst_before = rq_seen;
    // Randomised traffic.
    for (int c = 0; c < 4000; c++) begin
      logic p, r;
      if ($urandom_range(0, 7) == 0) init = ~init;
      p = ($urandom_range(0, 149) == 0);
      r = ($urandom_range(0, 699) != 0);
      drive(p, init, r, (p && $urandom_range(0, 3) == 0) ? int'($urandom_range(2, 4)) : 1);
    end
    drive(1'b0, init, 1'b1, 2);
    @(negedge clk);
    total = total + 1;
    if (rst_before < 2) begin
      bad = bad + 1;
      $display("FAIL retry_pulses: got %0d want >=2", rst_before);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/domain_reset_responder.md
# domain_reset_responder

Per-domain responder for the one-cycle reset pulses issued by the system reset generator (MCU, MAC and symbol domains). One instance sits in each clock domain. It turns the incoming pulse into a stretched local reset and then waits for the local datapath to report initialisation done. It reports domain readiness, retries initialisation a bounded number of times on timeout, and flags a fault when retries are exhausted.

## Interface
Parameters:
- HOLD_CYCLES, 16: cycles LOCAL_RST stays high after an accepted RST_PULSE or retry; legal range ≥1.
- TIMEOUT_CYCLES, 1024: cycles allowed in WAIT_RDY for INIT_DONE before a timeout; legal range ≥1.
- MAX_RETRY, 3: automatic retries before FAULT; legal range ≥0.

Ports:
- SYS_CLK  in  1  domain clock (the instance is connected to SYS_CLK, SERIAL_CLK or SYMBOL_CLK; the port name is SYS_CLK).
- RST_N  in  1  asynchronous, active-low reset.
- RST_PULSE  in  1  one-cycle reset request from the reset generator, already synchronous to SYS_CLK.
- INIT_DONE  in  1  level from the local datapath, synchronous to SYS_CLK; high means initialisation is complete.
- LOCAL_RST  out  1  active-high reset to the local datapath.
- DOMAIN_READY  out  1  high while the domain is initialised.
- RETRY_REQ  out  1  one-cycle pulse on each automatic retry.
- TIMEOUT_ERR  out  1  high in FAULT.
- RETRY_CNT  out  $clog2(MAX_RETRY+1) (minimum 1)  retries used since the last accepted RST_PULSE.

## Operation
- All outputs are registered. Counter width is $clog2(max(HOLD_CYCLES,TIMEOUT_CYCLES)+1).
- States:
  - IDLE: LOCAL_RST=1; waits for RST_PULSE.
  - HOLD: LOCAL_RST=1; counts HOLD_CYCLES cycles.
  - WAIT_RDY: LOCAL_RST=0; counts up to TIMEOUT_CYCLES cycles while waiting for INIT_DONE.
  - READY: DOMAIN_READY=1.
  - FAULT: LOCAL_RST=1, TIMEOUT_ERR=1.
- Transitions:
  - RST_PULSE in any state → HOLD. Counter cleared, RETRY_CNT cleared, DOMAIN_READY and TIMEOUT_ERR cleared.
  - HOLD, counter reaches HOLD_CYCLES → WAIT_RDY, counter cleared.
  - WAIT_RDY, INIT_DONE=1 → READY.
  - WAIT_RDY, counter reaches TIMEOUT_CYCLES with INIT_DONE=0:
    - if RETRY_CNT<MAX_RETRY → HOLD, RETRY_CNT+1, RETRY_REQ pulse.
    - otherwise → FAULT.
  - READY, INIT_DONE=0 → WAIT_RDY, counter cleared, DOMAIN_READY dropped. RETRY_CNT is kept.
  - FAULT is left only by RST_PULSE or RST_N.
- INIT_DONE is ignored in IDLE, HOLD and FAULT.
- RETRY_CNT saturates at MAX_RETRY. With MAX_RETRY=0, the first timeout goes directly to FAULT.

## Timing
- Reset values (RST_N low, asynchronous): state IDLE, LOCAL_RST=1, DOMAIN_READY=0, RETRY_REQ=0, TIMEOUT_ERR=0, RETRY_CNT=0, counters 0.
- RST_N low mid-operation returns the block to IDLE immediately. Releasing RST_N does not start a sequence; an RST_PULSE is required.
- Hold length: when RST_PULSE is sampled at edge E, LOCAL_RST stays high through edge E+HOLD_CYCLES and is low from edge E+HOLD_CYCLES+1.
- Ready latency: INIT_DONE sampled high at edge E while in WAIT_RDY gives DOMAIN_READY=1 after edge E, i.e. 1 cycle.
- Timeout: after TIMEOUT_CYCLES sampled edges in WAIT_RDY without INIT_DONE, the next edge asserts either:
  - RETRY_REQ (exactly one cycle) and LOCAL_RST=1, or
  - TIMEOUT_ERR=1 and LOCAL_RST=1.
- Priority for simultaneous events:
  - RST_PULSE beats INIT_DONE and timeout.
  - INIT_DONE beats timeout on the same edge; the result is READY, with no retry.
- RST_PULSE held high for several cycles restarts HOLD on each cycle it is high. The hold is measured from its last high cycle.

## Test plan
- RST_N release, then a single RST_PULSE, HOLD_CYCLES=16, INIT_DONE rising 5 cycles after LOCAL_RST falls → LOCAL_RST high for exactly 16 cycles after the pulse edge; DOMAIN_READY=1 one cycle after INIT_DONE is sampled; RETRY_CNT=0.
- TIMEOUT_CYCLES=8, MAX_RETRY=2, INIT_DONE held at 0 → two RETRY_REQ pulses, each followed by a 16-cycle LOCAL_RST hold; RETRY_CNT counts 1 then 2; the third timeout sets TIMEOUT_ERR=1 with LOCAL_RST=1, and the state stays in FAULT.
- In FAULT, apply RST_PULSE, then INIT_DONE=1 after the hold → TIMEOUT_ERR and RETRY_CNT clear at the pulse edge; DOMAIN_READY=1.
- In READY, drop INIT_DONE for 3 cycles, then raise it → DOMAIN_READY low for 3 cycles; LOCAL_RST stays 0; no RETRY_REQ.
- INIT_DONE rising on the exact timeout edge → READY, no RETRY_REQ. RST_PULSE coincident with INIT_DONE in WAIT_RDY → HOLD restarts and DOMAIN_READY stays 0.
- RST_N asserted mid-HOLD and mid-WAIT_RDY → all outputs go to reset values immediately; no activity until the next RST_PULSE.
